// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Clock cycles per bit, truncated.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Cycles from start-bit edge to start-bit centre.
  function automatic int calc_half(input int clk_freq, input int baud);
    return calc_div(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give metastability settling time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART 8N1 receiver: start-bit qualification, mid-bit sampling,
// one-entry output buffer with framing-error and overrun pulses.
//
// state | meaning
// IDLE  | line high, waiting for a falling edge
// START | counting to the centre of the start bit
// DATA  | sampling the eight data bits at bit centres
// STOP  | counting to the centre of the stop bit
// BREAK | stop bit was low; waiting for the line to return high
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE       = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV   = calc_div(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int HALF  = calc_half(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  rx_state_t      state;
  rx_state_t      state_next;
  logic           rxs;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [7:0]     shift_reg;
  logic           cnt_zero;
  logic           load_half;
  logic           load_div;
  logic           shift_en;
  logic           idx_clear;
  logic           deliver;
  logic           ferr_set;

  sync_2ff #(.RST_VAL(1'b1)) u_rxd_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs)
  );

  assign cnt_zero = (cnt == '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!rxs) state_next = START;
      START: if (cnt_zero) state_next = rxs ? IDLE : DATA;
      DATA:  if (cnt_zero && bit_idx == LAST_IDX) state_next = STOP;
      STOP:  if (cnt_zero) state_next = rxs ? IDLE : BREAK;
      BREAK: if (rxs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-state control strobes for the counters and output buffer.
  always_comb begin
    load_half = 1'b0;
    load_div  = 1'b0;
    shift_en  = 1'b0;
    idx_clear = 1'b0;
    deliver   = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE:  load_half = !rxs;
      START: begin
        load_div  = cnt_zero && !rxs;
        idx_clear = cnt_zero && !rxs;
      end
      DATA: begin
        load_div = cnt_zero;
        shift_en = cnt_zero;
      end
      STOP: begin
        deliver  = cnt_zero && rxs;
        ferr_set = cnt_zero && !rxs;
      end
      default: ;
    endcase
  end

  // Bit-period down-counter, bit index and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      if (load_half)     cnt <= HALF_LOAD;
      else if (load_div) cnt <= DIV_LOAD;
      else if (!cnt_zero) cnt <= cnt - 1'b1;

      if (idx_clear)     bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 1'b1;

      if (shift_en) shift_reg[bit_idx] <= rxs;
    end
  end

  // One-entry output buffer; an unconsumed byte is never overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= deliver && valid && !ready;
      if (deliver) begin
        if (!valid || ready) begin
          data  <= shift_reg;
          valid <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend at default rates.
module tb_uart_rx_frontend;

  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 115200;
  localparam int DIVC   = CLK_HZ / BAUD;
  localparam int HALFC  = DIVC / 2;
  localparam int LAT    = 2 + HALFC + 9 * DIVC + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] got_q[$];
  int         got_t[$];
  int         ferr_cnt;
  int         ovr_cnt;
  int         vhigh_cnt;

  uart_rx_frontend #(
    .CLOCK_FREQUENCY (CLK_HZ),
    .BAUD_RATE       (BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: log accepted bytes with their cycle, count pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) vhigh_cnt++;
      if (valid && ready) begin
        got_q.push_back(data);
        got_t.push_back(cyc);
      end
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_t.delete();
    ferr_cnt  = 0;
    ovr_cnt   = 0;
    vhigh_cnt = 0;
  endtask

  // Drive one 8N1 frame; rxd is left at the stop-bit level.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int t0);
    t0  = cyc;
    rxd = 1'b0;
    hold(DIVC);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      hold(DIVC);
    end
    rxd = stop_bit;
    hold(DIVC);
  endtask

  task automatic test_reset();
    rst = 1'b1; rxd = 1'b1; ready = 1'b0;
    hold(5);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", overrun); end
    rst = 1'b0;
    hold(5);
  endtask

  task automatic test_single();
    int t0;
    clear_mon();
    ready = 1'b1;
    send_byte(8'h55, 1'b1, t0);
    hold(10);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL single_count got %0d exp 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== 8'h55) begin errors++; $display("FAIL single_data got %h exp 55", got_q[0]); end
      checks++; if (got_t[0] !== t0 + LAT) begin errors++; $display("FAIL single_time got %0d exp %0d", got_t[0], t0 + LAT); end
    end
    checks++; if (vhigh_cnt !== 1) begin errors++; $display("FAIL single_valid_width got %0d exp 1", vhigh_cnt); end
    checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL single_ferr got %0d exp 0", ferr_cnt); end
    checks++; if (ovr_cnt !== 0) begin errors++; $display("FAIL single_ovr got %0d exp 0", ovr_cnt); end
  endtask

  task automatic test_back_to_back();
    int t0;
    clear_mon();
    ready = 1'b1;
    send_byte(8'h00, 1'b1, t0);
    send_byte(8'hFF, 1'b1, t0);
    hold(10);
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", got_q.size()); end
    if (got_q.size() == 2) begin
      checks++; if (got_q[0] !== 8'h00) begin errors++; $display("FAIL b2b_first got %h exp 00", got_q[0]); end
      checks++; if (got_q[1] !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h exp ff", got_q[1]); end
      checks++; if (got_t[1] - got_t[0] !== 10 * DIVC) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", got_t[1] - got_t[0], 10 * DIVC); end
    end
    checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL b2b_ferr got %0d exp 0", ferr_cnt); end
  endtask

  task automatic test_glitch();
    int t0;
    logic [7:0] rb;
    clear_mon();
    ready = 1'b1;
    rxd = 1'b0;
    hold(200);
    rxd = 1'b1;
    hold(HALFC + 20);
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL glitch_count got %0d exp 0", got_q.size()); end
    checks++; if (vhigh_cnt !== 0) begin errors++; $display("FAIL glitch_valid got %0d exp 0", vhigh_cnt); end
    checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL glitch_ferr got %0d exp 0", ferr_cnt); end
    rb = 8'($urandom_range(0, 255));
    send_byte(rb, 1'b1, t0);
    hold(10);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL post_glitch_count got %0d exp 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== rb) begin errors++; $display("FAIL post_glitch_data got %h exp %h", got_q[0], rb); end
      checks++; if (got_t[0] !== t0 + LAT) begin errors++; $display("FAIL post_glitch_time got %0d exp %0d", got_t[0], t0 + LAT); end
    end
  endtask

  task automatic test_frame_err();
    int t0;
    clear_mon();
    ready = 1'b1;
    send_byte(8'hA5, 1'b0, t0);
    hold(3 * DIVC);
    rxd = 1'b1;
    hold(DIVC);
    send_byte(8'h3C, 1'b1, t0);
    hold(10);
    checks++; if (ferr_cnt !== 1) begin errors++; $display("FAIL ferr_pulses got %0d exp 1", ferr_cnt); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== 8'h3C) begin errors++; $display("FAIL ferr_next_data got %h exp 3c", got_q[0]); end
    end
    checks++; if (ovr_cnt !== 0) begin errors++; $display("FAIL ferr_ovr got %0d exp 0", ovr_cnt); end
  endtask

  task automatic test_overrun();
    int t0;
    clear_mon();
    ready = 1'b0;
    send_byte(8'h12, 1'b1, t0);
    send_byte(8'h34, 1'b1, t0);
    hold(10);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", valid); end
    checks++; if (data !== 8'h12) begin errors++; $display("FAIL ovr_data got %h exp 12", data); end
    checks++; if (ovr_cnt !== 1) begin errors++; $display("FAIL ovr_pulses got %0d exp 1", ovr_cnt); end
    ready = 1'b1;
    hold(1);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", valid); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL ovr_accept_count got %0d exp 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== 8'h12) begin errors++; $display("FAIL ovr_accept_data got %h exp 12", got_q[0]); end
    end
  endtask

  task automatic test_reset_midframe();
    int t0;
    logic [7:0] b;
    b = 8'h77;
    clear_mon();
    ready = 1'b1;
    rxd = 1'b0;
    hold(DIVC);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      hold(DIVC);
    end
    rxd = b[4];
    hold(400);
    rst = 1'b1;
    #1;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h exp 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", valid); end
    checks++; if ({frame_err, overrun} !== 2'b00) begin errors++; $display("FAIL midrst_pulses got %b exp 00", {frame_err, overrun}); end
    hold(5);
    rst = 1'b0;
    rxd = 1'b1;
    hold(DIVC);
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL midrst_nodeliver got %0d exp 0", got_q.size()); end
    send_byte(8'h77, 1'b1, t0);
    hold(10);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL midrst_next_count got %0d exp 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== 8'h77) begin errors++; $display("FAIL midrst_next_data got %h exp 77", got_q[0]); end
    end
    checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL midrst_ferr got %0d exp 0", ferr_cnt); end
  endtask

  initial begin
    rst   = 1'b1;
    rxd   = 1'b1;
    ready = 1'b0;
    clear_mon();
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
